// File: rtl/dff_toggle_monitor.sv
// WIDTH-bit D register with Q/Q_bar and a switching-activity accumulator.
// A snapshot path captures the running toggle count for an activity collector.
module dff_toggle_monitor #(
  parameter int WIDTH         = 8,
  parameter int CNT_W         = 16,
  parameter bit SATURATE      = 1'b1,
  parameter bit CLEAR_ON_SNAP = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  input  logic             clear,
  input  logic             snap_req,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic [CNT_W-1:0] toggle_acc,
  output logic             overflow,
  output logic             snap_valid,
  output logic [CNT_W-1:0] snap_count
);

  localparam int TW = $clog2(WIDTH + 1);
  localparam int SW = ((CNT_W > TW) ? CNT_W : TW) + 1;
  localparam logic [SW-1:0] MAXV =
    {{(SW-CNT_W){1'b0}}, {CNT_W{1'b1}}};

  logic [WIDTH-1:0] r_q;
  logic [CNT_W-1:0] r_acc;
  logic             r_ovf;
  logic             r_sv;
  logic [CNT_W-1:0] r_sc;

  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_diff;
  logic [TW-1:0]    w_tog;
  logic [SW-1:0]    w_sum;
  logic [CNT_W-1:0] w_val;
  logic             w_hit;
  logic             w_zero;

  assign w_next = en ? d : r_q;
  assign w_diff = w_next ^ r_q;

  always_comb begin
    w_tog = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_tog = w_tog + TW'(w_diff[i]);
    end
  end

  assign w_sum = SW'(r_acc) + SW'(w_tog);

  // Saturating mode flags on reaching the max; wrap mode on carry out.
  always_comb begin
    w_val = w_sum[CNT_W-1:0];
    w_hit = 1'b0;
    if (SATURATE) begin
      w_hit = (w_sum >= MAXV);
      if (w_hit) begin
        w_val = '1;
      end
    end else begin
      w_hit = (w_sum > MAXV);
    end
  end

  assign w_zero = clear | (snap_req & CLEAR_ON_SNAP);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q   <= '0;
      r_acc <= '0;
      r_ovf <= 1'b0;
      r_sv  <= 1'b0;
      r_sc  <= '0;
    end else begin
      if (en) begin
        r_q <= d;
      end
      if (w_zero) begin
        r_acc <= '0;
        r_ovf <= 1'b0;
      end else begin
        r_acc <= w_val;
        r_ovf <= r_ovf | w_hit;
      end
      r_sv <= snap_req;
      if (snap_req) begin
        r_sc <= w_val;
      end
    end
  end

  assign q          = r_q;
  assign q_bar      = ~r_q;
  assign toggle_acc = r_acc;
  assign overflow   = r_ovf;
  assign snap_valid = r_sv;
  assign snap_count = r_sc;

endmodule
